// File: rtl/memory_stage_pkg.sv
// Shared types for the memory stage: control bundle layout, access sizes, FSM states, byte-lane masks.
// Pure declarations; no latency or flow-control behaviour of its own.
package memory_stage_pkg;

    localparam logic [1:0] SZ_WORD = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_BYTE = 2'b10;

    localparam logic [3:0] BE_WORD    = 4'b1111;
    localparam logic [3:0] BE_HALF_LO = 4'b0011;
    localparam logic [3:0] BE_HALF_HI = 4'b1100;
    localparam logic [3:0] BE_BYTE0   = 4'b0001;

    // Field order mirrors the execute-stage bundle, bit 7 down to bit 0.
    typedef struct packed {
        logic       link;
        logic       load_unsigned;
        logic [1:0] size;
        logic       mem_to_reg;
        logic       reg_write;
        logic       mem_write;
        logic       mem_read;
    } bundle_t;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_WAIT = 1'b1
    } state_e;

    function automatic logic is_aligned(input logic [1:0] size, input logic [1:0] lo);
        case (size)
            SZ_HALF: return !lo[0];
            SZ_BYTE: return 1'b1;
            default: return (lo == 2'b00);
        endcase
    endfunction

    function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] lo);
        case (size)
            SZ_HALF: return lo[1] ? BE_HALF_HI : BE_HALF_LO;
            SZ_BYTE: return BE_BYTE0 << lo;
            default: return BE_WORD;
        endcase
    endfunction

endpackage

// File: rtl/memory_stage_if.sv
// Data-memory req/ack bus: master is the memory stage, slave is the memory.
// Request is held until ack or abandonment; rdata is only meaningful alongside ack.
interface memory_stage_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ack;

    modport master (output req, we, addr, be, wdata, input rdata, ack);
    modport slave  (input req, we, addr, be, wdata, output rdata, ack);
endinterface

// File: rtl/memory_stage_load_align.sv
// Extracts a byte/half/word from the load data lanes and sign- or zero-extends it.
// Purely combinational; no flow control.
module memory_stage_load_align
    import memory_stage_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [1:0]  size_i,
    input  logic        unsigned_i,
    output logic [31:0] data_o
);
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        case (addr_lo_i)
            2'd0:    byte_sel = rdata_i[7:0];
            2'd1:    byte_sel = rdata_i[15:8];
            2'd2:    byte_sel = rdata_i[23:16];
            default: byte_sel = rdata_i[31:24];
        endcase
        half_sel = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];

        case (size_i)
            SZ_BYTE: data_o = {{24{!unsigned_i & byte_sel[7]}}, byte_sel};
            SZ_HALF: data_o = {{16{!unsigned_i & half_sel[15]}}, half_sel};
            default: data_o = rdata_i;
        endcase
    end
endmodule

// File: rtl/register.sv
// Generic enable-able register with async active-low clear.
// One-cycle latency; holds its value while en_i is low.
module register #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             en_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);
    logic [WIDTH-1:0] data_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            data_q <= '0;
        end else if (en_i) begin
            data_q <= d_i;
        end
    end

    assign q_o = data_q;
endmodule

// File: rtl/memory_stage.sv
// Memory-access stage: input regs -> req/ack data memory -> registered write-back; 1 edge per op plus wait cycles.
// Stalls upstream while a request waits for ack; a request with no ack after MAX_WAIT wait cycles is abandoned as an error.
module memory_stage
    import memory_stage_pkg::*;
#(
    parameter int MAX_WAIT = 15
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [7:0]           bundle_i,
    input  logic [31:0]          pc_seq_i,
    input  logic [31:0]          alu_i,
    input  logic [31:0]          reg_read2_i,
    input  logic [4:0]           reg_write_dest_i,
    output logic                 stall_o,
    memory_stage_if.master       mem,
    output logic                 wb_reg_write_o,
    output logic [4:0]           wb_dest_o,
    output logic [31:0]          wb_data_o,
    output logic                 mem_error_o
);
    localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

    logic [7:0]  bundle_raw;
    bundle_t     bundle_q;
    logic [31:0] pc_q, alu_q, read2_q;
    logic [4:0]  dest_q;

    state_e      state_q, state_d;
    logic [7:0]  wait_cnt_q, wait_cnt_d;

    logic        stall, capture_en;
    logic        is_mem, is_load, aligned, access;
    logic        mem_req, timeout, err_now;
    logic [31:0] store_data, load_val;
    logic        wb_we_d, error_d;
    logic [31:0] wb_data_d;

    assign capture_en = !stall;

    register #(.WIDTH(8))  u_bundle_reg (.clk_i, .rst_ni, .en_i(capture_en), .d_i(bundle_i),         .q_o(bundle_raw));
    register #(.WIDTH(32)) u_pc_reg     (.clk_i, .rst_ni, .en_i(capture_en), .d_i(pc_seq_i),         .q_o(pc_q));
    register #(.WIDTH(32)) u_alu_reg    (.clk_i, .rst_ni, .en_i(capture_en), .d_i(alu_i),            .q_o(alu_q));
    register #(.WIDTH(32)) u_read2_reg  (.clk_i, .rst_ni, .en_i(capture_en), .d_i(reg_read2_i),      .q_o(read2_q));
    register #(.WIDTH(5))  u_dest_reg   (.clk_i, .rst_ni, .en_i(capture_en), .d_i(reg_write_dest_i), .q_o(dest_q));

    assign bundle_q = bundle_t'(bundle_raw);

    assign is_mem  = bundle_q.mem_read | bundle_q.mem_write;
    assign is_load = bundle_q.mem_read & !bundle_q.mem_write;
    assign aligned = is_aligned(bundle_q.size, alu_q[1:0]);
    assign access  = is_mem & aligned;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ST_RUN;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        mem_req    = 1'b0;
        timeout    = 1'b0;
        case (state_q)
            ST_RUN: begin
                mem_req = access;
                if (access && !mem.ack) begin
                    state_d    = ST_WAIT;
                    wait_cnt_d = 8'd1;
                end
            end
            ST_WAIT: begin
                mem_req = 1'b1;
                timeout = !mem.ack && (wait_cnt_q == MAX_WAIT_C);
                if (mem.ack || timeout) begin
                    state_d    = ST_RUN;
                    wait_cnt_d = '0;
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
            end
            default: begin
                state_d    = ST_RUN;
                wait_cnt_d = '0;
            end
        endcase
    end

    // On a timeout the request is still driven this cycle but the stage releases upstream.
    assign stall   = mem_req & !mem.ack & !timeout;
    assign stall_o = stall;
    assign err_now = ((state_q == ST_RUN) && is_mem && !aligned) || timeout;

    always_comb begin
        case (bundle_q.size)
            SZ_BYTE: store_data = {4{read2_q[7:0]}};
            SZ_HALF: store_data = {2{read2_q[15:0]}};
            default: store_data = read2_q;
        endcase
    end

    // Bus outputs are gated so an idle or reset stage presents an all-zero bus.
    assign mem.req   = mem_req;
    assign mem.we    = mem_req & bundle_q.mem_write;
    assign mem.addr  = mem_req ? {alu_q[31:2], 2'b00} : '0;
    assign mem.be    = mem_req ? lane_mask(bundle_q.size, alu_q[1:0]) : '0;
    assign mem.wdata = (mem_req & bundle_q.mem_write) ? store_data : '0;

    memory_stage_load_align u_load_align (
        .rdata_i   (mem.rdata),
        .addr_lo_i (alu_q[1:0]),
        .size_i    (bundle_q.size),
        .unsigned_i(bundle_q.load_unsigned),
        .data_o    (load_val)
    );

    // Stall edges insert a write-back bubble so the previous write is not repeated.
    assign wb_we_d   = !stall & bundle_q.reg_write & !err_now & (dest_q != 5'd0);
    assign wb_data_d = bundle_q.link                     ? pc_q     :
                       (is_load && bundle_q.mem_to_reg)  ? load_val : alu_q;
    assign error_d   = mem_error_o | err_now;

    register #(.WIDTH(1))  u_wb_we_reg   (.clk_i, .rst_ni, .en_i(1'b1),       .d_i(wb_we_d),   .q_o(wb_reg_write_o));
    register #(.WIDTH(5))  u_wb_dest_reg (.clk_i, .rst_ni, .en_i(capture_en), .d_i(dest_q),    .q_o(wb_dest_o));
    register #(.WIDTH(32)) u_wb_data_reg (.clk_i, .rst_ni, .en_i(capture_en), .d_i(wb_data_d), .q_o(wb_data_o));
    register #(.WIDTH(1))  u_error_reg   (.clk_i, .rst_ni, .en_i(1'b1),       .d_i(error_d),   .q_o(mem_error_o));

endmodule

// File: tb/tb_memory_stage.sv
// Scoreboard bench for memory_stage: directed scenarios then random ops against a behavioural model.
module tb_memory_stage;
    localparam int MAXW = 15;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic        we;
        int          w;
        logic [31:0] rdata;
    } acc_t;

    typedef struct {
        logic [4:0]  dest;
        logic [31:0] data;
    } wb_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  bundle;
    logic [31:0] pc_seq, alu, rd2;
    logic [4:0]  dest;
    logic        stall, wb_reg_write, mem_error;
    logic [4:0]  wb_dest;
    logic [31:0] wb_data;

    memory_stage_if mif ();

    memory_stage #(.MAX_WAIT(MAXW)) dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .bundle_i        (bundle),
        .pc_seq_i        (pc_seq),
        .alu_i           (alu),
        .reg_read2_i     (rd2),
        .reg_write_dest_i(dest),
        .stall_o         (stall),
        .mem             (mif),
        .wb_reg_write_o  (wb_reg_write),
        .wb_dest_o       (wb_dest),
        .wb_data_o       (wb_data),
        .mem_error_o     (mem_error)
    );

    always #5 clk = ~clk;

    acc_t acc_q[$];
    wb_t  wb_q[$];
    int   total = 0, bad = 0;
    int   exp_stall = 0, got_stall = 0, exp_req = 0, got_req = 0;
    bit   model_err = 1'b0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: what one captured op should do on the bus and at write-back.
    task automatic model(input logic [7:0] bun, input logic [31:0] pc, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] d, input int w, input logic [31:0] rdata);
        logic        rd, wr, rw, m2r, uns, lnk, ok;
        logic [1:0]  sz;
        logic [31:0] shifted, ldv;
        bit          err;
        int          v, waits;
        acc_t        ac;
        wb_t         e;
        rd = bun[0]; wr = bun[1]; rw = bun[2]; m2r = bun[3];
        sz = bun[5:4]; uns = bun[6]; lnk = bun[7];
        err = 1'b0;
        ok = (sz == 2'b01) ? (a[0] == 1'b0) : (sz == 2'b10) ? 1'b1 : (a[1:0] == 2'b00);
        if ((rd || wr) && !ok) begin
            err = 1'b1;
        end else if (rd || wr) begin
            ac.addr  = a & 32'hFFFF_FFFC;
            ac.we    = wr;
            ac.be    = (sz == 2'b10) ? 4'(1 << a[1:0]) : (sz == 2'b01) ? 4'(3 << (2 * a[1])) : 4'hF;
            ac.wdata = (sz == 2'b10) ? {24'b0, b[7:0]} * 32'h0101_0101 :
                       (sz == 2'b01) ? {16'b0, b[15:0]} * 32'h0001_0001 : b;
            ac.w     = w;
            ac.rdata = rdata;
            acc_q.push_back(ac);
            waits = (w < MAXW) ? w : MAXW;
            exp_stall += waits;
            exp_req   += waits + 1;
            if (w > MAXW) err = 1'b1;
        end
        if (err) model_err = 1'b1;
        shifted = rdata >> (8 * a[1:0]);
        if (sz == 2'b10) begin
            v = int'(shifted[7:0]);
            if (!uns && v > 127) v -= 256;
            ldv = 32'(v);
        end else if (sz == 2'b01) begin
            v = int'(shifted[15:0]);
            if (!uns && v > 32767) v -= 65536;
            ldv = 32'(v);
        end else begin
            ldv = rdata;
        end
        if (rw && d != 5'd0 && !err) begin
            e.dest = d;
            e.data = lnk ? pc : (rd && !wr && m2r) ? ldv : a;
            wb_q.push_back(e);
        end
    endtask

    // Present an op and return 1ns after the edge that captures it.
    task automatic issue(input logic [7:0] bun, input logic [31:0] pc, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] d, input int w, input logic [31:0] rdata);
        logic s;
        int   guard;
        bundle = bun; pc_seq = pc; alu = a; rd2 = b; dest = d;
        guard = 0;
        do begin
            @(negedge clk);
            #2;
            s = stall;
            @(posedge clk);
            guard++;
        end while (s && guard < 2000);
        if (s) begin
            bad++;
            $display("FAIL capture: stall_out still 1 after %0d cycles, expected release", guard);
            $display("test done: total=%0d bad=%0d", total, bad);
            $fatal(1);
        end
        model(bun, pc, a, b, d, w, rdata);
        #1;
    endtask

    // Memory responder: acks after the op's wait count and checks bus and stall each request cycle.
    int   idx = 0;
    acc_t ra;
    always @(negedge clk) begin
        mif.ack   = 1'b0;
        mif.rdata = $urandom;
        if (!rst_n) begin
            idx = 0;
        end else if (mif.req) begin
            if (acc_q.size() == 0) begin
                total++; bad++;
                $display("FAIL req_unexpected: mem_req=1 expected 0 at %0t", $time);
            end else begin
                ra = acc_q[0];
                chk("mem_we", 32'(mif.we), 32'(ra.we));
                chk("mem_addr", mif.addr, ra.addr);
                if (ra.we) begin
                    chk("mem_be", 32'(mif.be), 32'(ra.be));
                    chk("mem_wdata", mif.wdata, ra.wdata);
                end
                if (idx == ra.w) begin
                    mif.ack   = 1'b1;
                    mif.rdata = ra.rdata;
                end
                #1;
                chk("stall_out", 32'(stall), (idx == ra.w || idx == MAXW) ? 32'd0 : 32'd1);
                if (stall) got_stall++;
                got_req++;
                if (mif.ack || idx == MAXW) begin
                    void'(acc_q.pop_front());
                    idx = 0;
                end else begin
                    idx++;
                end
            end
        end else begin
            if (acc_q.size() != 0) begin
                total++; bad++;
                $display("FAIL req_missing: mem_req=0 expected 1 at %0t", $time);
            end
            if ($urandom_range(3) == 0) mif.ack = 1'b1;
        end
    end

    wb_t we_exp;
    always @(negedge clk) begin
        if (rst_n === 1'b1 && wb_reg_write === 1'b1) begin
            if (wb_q.size() == 0) begin
                total++; bad++;
                $display("FAIL wb_unexpected: wb_reg_write=1 dest=%0d expected 0", wb_dest);
            end else begin
                we_exp = wb_q.pop_front();
                chk("wb_dest", 32'(wb_dest), 32'(we_exp.dest));
                chk("wb_data", wb_data, we_exp.data);
            end
        end
    end

    initial begin
        int st0, rq0, r, w;
        rst_n = 1'b0;
        bundle = '0; pc_seq = '0; alu = '0; rd2 = '0; dest = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_mem_req", 32'(mif.req), 32'd0);
        chk("rst_wb_we", 32'(wb_reg_write), 32'd0);
        chk("rst_wb_data", wb_data, 32'd0);
        chk("rst_mem_error", 32'(mem_error), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        st0 = got_stall;
        issue(8'h0D, 32'h0, 32'h0000_0100, 32'h0, 5'd5, 2, 32'h8000_00F0);
        issue(8'h2D, 32'h0, 32'h0000_0103, 32'h0, 5'd6, 0, 32'h8500_0000);
        chk("stall_cycles_2wait", 32'(got_stall - st0), 32'd2);
        issue(8'h6D, 32'h0, 32'h0000_0103, 32'h0, 5'd7, 0, 32'h8500_0000);
        issue(8'h16, 32'h0, 32'h0000_0202, 32'h1234_ABCD, 5'd8, 1, 32'h0);
        chk("no_error_yet", 32'(mem_error), 32'd0);
        issue(8'h0D, 32'h0, 32'h0000_0101, 32'h0, 5'd9, 0, 32'h0);
        issue(8'h04, 32'h0, 32'h0000_0055, 32'h0, 5'd10, 0, 32'h0);
        chk("misaligned_error", 32'(mem_error), 32'd1);
        rq0 = got_req;
        st0 = got_stall;
        issue(8'h0D, 32'h0, 32'h0000_0400, 32'h0, 5'd11, 100, 32'h0);
        issue(8'h04, 32'h0, 32'h0000_0077, 32'h0, 5'd12, 0, 32'h0);
        chk("timeout_req_cycles", 32'(got_req - rq0), 32'(MAXW + 1));
        chk("timeout_stall_cycles", 32'(got_stall - st0), 32'(MAXW));

        for (int i = 0; i < 300; i++) begin
            r = $urandom_range(15);
            w = (r < 12) ? (r % 4) : (r < 14) ? MAXW : MAXW + r;
            issue(8'($urandom), $urandom, $urandom, $urandom, 5'($urandom_range(31)), w, $urandom);
        end
        issue(8'h00, 32'h0, 32'h0, 32'h0, 5'd0, 0, 32'h0);
        repeat (3) @(negedge clk);
        #2;
        chk("wb_queue_drained", 32'(wb_q.size()), 32'd0);
        chk("acc_queue_drained", 32'(acc_q.size()), 32'd0);
        chk("total_stall_cycles", 32'(got_stall), 32'(exp_stall));
        chk("total_req_cycles", 32'(got_req), 32'(exp_req));
        chk("sticky_error", 32'(mem_error), 32'(model_err));

        @(posedge clk);
        #1;
        issue(8'h84, 32'h0040_0008, 32'h0000_1234, 32'h0, 5'd3, 0, 32'h0);
        issue(8'h0D, 32'h0, 32'h0000_0300, 32'h0, 5'd4, 1000, 32'h0);
        repeat (3) @(negedge clk);
        #3;
        chk("link_written", 32'(wb_q.size()), 32'd0);
        chk("wait_req_high", 32'(mif.req), 32'd1);
        rst_n = 1'b0;
        #1;
        acc_q.delete();
        chk("arst_mem_req", 32'(mif.req), 32'd0);
        chk("arst_stall", 32'(stall), 32'd0);
        chk("arst_mem_be", 32'(mif.be), 32'd0);
        chk("arst_mem_addr", mif.addr, 32'd0);
        chk("arst_wb_we", 32'(wb_reg_write), 32'd0);
        chk("arst_wb_dest", 32'(wb_dest), 32'd0);
        chk("arst_wb_data", wb_data, 32'd0);
        chk("arst_mem_error", 32'(mem_error), 32'd0);
        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
